buffer_circ_var: RTL

//  Next-generation circular buffer: parametrised width/depth, variable-count multi-word

---
 rtl/buffer_circ_pkg.sv | 27 ++
 rtl/circ_ptr.sv | 39 +++
 rtl/buffer_circ_var.sv | 119 +++++++++++
 3 files changed

// File: rtl/buffer_circ_pkg.sv
// Shared helpers for the variable-count circular buffer.
// Width function, default widths and modulo pointer add.
package buffer_circ_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int CW = clog2(4 + 1);
  localparam int CR = clog2(2 + 1);
  localparam int CN = clog2(16 + 1);

  // operands are below m, so one subtract is enough
  function automatic int wrap_add(
    input int a,
    input int b,
    input int m
  );
    int s;
    s = a + b;
    return (s >= m) ? s - m : s;
  endfunction

endpackage

// File: rtl/circ_ptr.sv
// Registered ring pointer with modulo advance.
// Also exposes ptr+k mod DEPTH for k < STEP_MAX.
module circ_ptr
  import buffer_circ_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int STEP_MAX = 4,
  parameter int AW = (DEPTH > 1) ? clog2(DEPTH) : 1,
  parameter int SW = clog2(STEP_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   adv,
  input  logic [SW-1:0]          step,
  output logic [AW-1:0]          ptr,
  output logic [STEP_MAX*AW-1:0] offs
);

  // pointer register, cleared by reset or flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= AW'(wrap_add(int'(ptr), int'(step), DEPTH));
    end
  end

  // lane addresses relative to the pointer
  always_comb begin
    offs = '0;
    for (int k = 0; k < STEP_MAX; k++) begin
      offs[k*AW +: AW] = AW'(wrap_add(int'(ptr), k, DEPTH));
    end
  end

endmodule

// File: rtl/buffer_circ_var.sv
// Circular buffer with multi-word write/read per cycle.
// Show-ahead output, level flags, sticky error flags.
module buffer_circ_var
  import buffer_circ_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int DEPTH     = 16,
  parameter int PAR_WRITE = 4,
  parameter int PAR_READ  = 2,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          wen,
  input  logic [clog2(PAR_WRITE+1)-1:0] wcnt,
  input  logic [PAR_WRITE*SIZE-1:0]     din,
  output logic                          ready,
  input  logic                          ren,
  input  logic [clog2(PAR_READ+1)-1:0]  rcnt,
  output logic [PAR_READ*SIZE-1:0]      dout,
  output logic                          valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [clog2(DEPTH+1)-1:0]     count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int NC = clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [SIZE-1:0]           mem [DEPTH];
  logic [AW-1:0]             wptr;
  logic [AW-1:0]             rptr;
  logic [PAR_WRITE*AW-1:0]   woff;
  logic [PAR_READ*AW-1:0]    roff;
  logic                      clr;
  logic                      wr_acc;
  logic                      rd_acc;
  int                        wa;
  int                        ra;

  assign ready = (int'(wcnt) <= PAR_WRITE) &&
                 (DEPTH - int'(count) >= int'(wcnt));
  assign valid = (int'(rcnt) <= PAR_READ) &&
                 (int'(count) >= int'(rcnt));

  assign clr    = flush;
  assign wr_acc = wen && ready && !flush;
  assign rd_acc = ren && valid && !flush;
  assign wa     = wr_acc ? int'(wcnt) : 0;
  assign ra     = rd_acc ? int'(rcnt) : 0;

  assign full         = int'(count) == DEPTH;
  assign empty        = count == '0;
  assign almost_full  = int'(count) >= AF_LEVEL;
  assign almost_empty = int'(count) <= AE_LEVEL;

  circ_ptr #(.DEPTH(DEPTH), .STEP_MAX(PAR_WRITE)) u_wptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .adv  (wr_acc),
    .step (wcnt),
    .ptr  (wptr),
    .offs (woff)
  );

  circ_ptr #(.DEPTH(DEPTH), .STEP_MAX(PAR_READ)) u_rptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .adv  (rd_acc),
    .step (rcnt),
    .ptr  (rptr),
    .offs (roff)
  );

  // storage writes, lanes beyond wcnt untouched
  always_ff @(posedge clk) begin
    for (int i = 0; i < PAR_WRITE; i++) begin
      if (rst && wr_acc && i < int'(wcnt)) begin
        mem[woff[i*AW +: AW]] <= din[i*SIZE +: SIZE];
      end
    end
  end

  // occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= NC'(int'(count) + wa - ra);
      if (wen && !ready) overflow <= 1'b1;
      if (ren && !valid) underflow <= 1'b1;
    end
  end

  // show-ahead read lanes, empty lanes forced to zero
  always_comb begin
    dout = '0;
    for (int j = 0; j < PAR_READ; j++) begin
      if (j < int'(count)) begin
        dout[j*SIZE +: SIZE] = mem[roff[j*AW +: AW]];
      end
    end
  end

endmodule
